// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and line-fill memory-side signals of the direct-mapped icache.
// slave = cache view, master = pipeline/memory environment view.
interface icache_direct_mapped_if;
   logic [31:0]  icache_addr;
   logic         icache_re;
   logic [31:0]  icache_dout;
   logic         icache_stall;
   logic         mem_req_valid;
   logic         mem_req_ready;
   logic [27:0]  mem_req_addr;
   logic         mem_resp_valid;
   logic [127:0] mem_resp_data;

   modport slave (
      input  icache_addr, icache_re, mem_req_ready, mem_resp_valid, mem_resp_data,
      output icache_dout, icache_stall, mem_req_valid, mem_req_addr
   );

   modport master (
      output icache_addr, icache_re, mem_req_ready, mem_resp_valid, mem_resp_data,
      input  icache_dout, icache_stall, mem_req_valid, mem_req_addr
   );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped blocking instruction cache: one-cycle hit path, single-beat
// 128-bit line refill on a miss, fence.i invalidate and hit/miss counters.
module icache_direct_mapped #(
   parameter int LINES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   icache_direct_mapped_if.slave bus,
   input  logic                  invalidate,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);
   localparam int INDEX_W = $clog2(LINES);
   localparam int TAG_W   = 28 - INDEX_W;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_MISS_REQ  = 2'd1,
      S_MISS_WAIT = 2'd2,
      S_FILLED    = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [29:0]        r_req_addr;
   logic               r_pending;
   logic               r_inv_pending;
   logic [LINES-1:0]   r_valid;
   logic [TAG_W-1:0]   r_tag  [LINES];
   logic [127:0]       r_data [LINES];
   logic [31:0]        r_dout;
   logic [31:0]        r_hit_count;
   logic [31:0]        r_miss_count;

   logic [1:0]         w_offset;
   logic [INDEX_W-1:0] w_index;
   logic [TAG_W-1:0]   w_tag;
   logic               w_lookup;
   logic               w_present;
   logic               w_hit;
   logic               w_miss;
   logic               w_stall;
   logic               w_accept_window;
   logic               w_resp_fire;

   function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] off);
      logic [31:0] word;
      case (off)
         2'd0:    word = line[31:0];
         2'd1:    word = line[63:32];
         2'd2:    word = line[95:64];
         2'd3:    word = line[127:96];
         default: word = 32'd0;
      endcase
      return word;
   endfunction

   // req_r holds byte address bits [31:2]; index/tag fields shift down by two
   assign w_offset  = r_req_addr[1:0];
   assign w_index   = r_req_addr[INDEX_W+1:2];
   assign w_tag     = r_req_addr[29:INDEX_W+2];
   assign w_lookup  = (r_state == S_IDLE) && r_pending;
   assign w_present = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_hit     = w_lookup && w_present;
   assign w_miss    = w_lookup && !w_present;
   assign w_resp_fire = (r_state == S_MISS_WAIT) && bus.mem_resp_valid;
   assign w_accept_window = ((r_state == S_IDLE) || (r_state == S_FILLED)) && !w_stall;

   assign bus.icache_dout   = r_dout;
   assign bus.icache_stall  = w_stall;
   assign bus.mem_req_valid = (r_state == S_MISS_REQ);
   assign bus.mem_req_addr  = r_req_addr[29:2];
   assign hit_count         = r_hit_count;
   assign miss_count        = r_miss_count;

   // Next-state decode and stall generation
   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_miss) begin
               w_next  = S_MISS_REQ;
               w_stall = 1'b1;
            end else begin
               w_next  = S_IDLE;
            end
         end
         S_MISS_REQ: begin
            w_stall = 1'b1;
            if (bus.mem_req_ready) begin
               w_next = S_MISS_WAIT;
            end else begin
               w_next = S_MISS_REQ;
            end
         end
         S_MISS_WAIT: begin
            w_stall = 1'b1;
            if (bus.mem_resp_valid) begin
               w_next = S_FILLED;
            end else begin
               w_next = S_MISS_WAIT;
            end
         end
         S_FILLED: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // State register and request capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_pending  <= 1'b0;
         r_req_addr <= 30'd0;
      end else begin
         r_state <= w_next;
         if (w_accept_window) begin
            r_pending <= bus.icache_re;
            if (bus.icache_re) begin
               r_req_addr <= bus.icache_addr[31:2];
            end
         end
      end
   end

   // Valid bits; an invalidate seen mid-miss is deferred to the FILLED->IDLE edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid       <= '0;
         r_inv_pending <= 1'b0;
      end else begin
         if (w_resp_fire) begin
            r_valid[w_index] <= 1'b1;
         end else if ((r_state == S_FILLED) && (r_inv_pending || invalidate)) begin
            r_valid <= '0;
         end else if ((r_state == S_IDLE) && invalidate) begin
            r_valid <= '0;
         end

         if (((r_state == S_MISS_REQ) || (r_state == S_MISS_WAIT)) && invalidate) begin
            r_inv_pending <= 1'b1;
         end else if (r_state == S_FILLED) begin
            r_inv_pending <= 1'b0;
         end
      end
   end

   // Output word and performance counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dout       <= 32'd0;
         r_hit_count  <= 32'd0;
         r_miss_count <= 32'd0;
      end else begin
         if (w_hit) begin
            r_dout <= sel_word(r_data[w_index], w_offset);
         end else if (w_resp_fire) begin
            r_dout <= sel_word(bus.mem_resp_data, w_offset);
         end
         if (w_hit) begin
            r_hit_count <= r_hit_count + 32'd1;
         end
         if (w_miss) begin
            r_miss_count <= r_miss_count + 32'd1;
         end
      end
   end

   // Tag and data arrays carry no reset; valid bits guard them
   always_ff @(posedge clk) begin
      if (w_resp_fire) begin
         r_data[w_index] <= bus.mem_resp_data;
         r_tag[w_index]  <= w_tag;
      end
   end
endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped, blocking instruction cache directly upstream of the pipeline fetch stage.
- Serves the datapath's icache_addr/icache_re/icache_dout port with synchronous one-cycle read.
- On a miss it raises stall and refills one 128-bit line from main memory over a valid/ready request channel and a valid-only response channel.
- Exposes hit/miss counters for performance CSRs.

Parameters:
- LINES, 64, number of cache lines (power of 2, ≥2); INDEX_W = log2(LINES).
- WORDS_PER_LINE, 4, fixed; offset = addr[3:2], index = addr[INDEX_W+3:4], tag = addr[31:INDEX_W+4].

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (asserted when 0)
- icache_addr  in  32  fetch byte address; bits [1:0] ignored
- icache_re  in  1  request strobe, sampled on clk edge
- icache_dout  out  32  fetched instruction word
- icache_stall  out  1  cache-induced pipeline stall
- invalidate  in  1  fence.i: clear all valid bits
- mem_req_valid  out  1  line-fill request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  28  line address (byte addr [31:4])
- mem_resp_valid  in  1  line data valid, one beat
- mem_resp_data  in  128  line data, word 0 in [31:0]
- hit_count  out  32  accepted lookups that hit
- miss_count  out  32  accepted lookups that missed

Behaviour:
- Reset (reset=0, async):
  - State IDLE; all valid bits 0; pending=0.
  - icache_dout=0; icache_stall=0; mem_req_valid=0; counters 0.
  - Tag and data arrays are not cleared.
- Accept: in IDLE or FILLED with icache_re=1 and icache_stall=0, the edge latches addr into req_r and sets pending=1. With icache_re=0, pending clears and icache_dout holds.
- Lookup (cycle after accept, state IDLE, pending=1): combinational compare of valid[index] and tag against req_r.
  - Hit: icache_dout = data[index][offset] (registered from the array read); icache_stall=0; hit_count+1 at that edge. A new accept may occur in the same cycle (back-to-back fetch, 1 word/cycle).
  - Miss: icache_stall=1 combinationally in that cycle; next state MISS_REQ; miss_count+1; icache_dout holds its previous value.
- MISS_REQ:
  - mem_req_valid=1; mem_req_addr=req_r[31:4], stable until handshake.
  - valid&ready edge → MISS_WAIT. icache_stall=1.
- MISS_WAIT:
  - mem_req_valid=0; icache_stall=1.
  - mem_resp_valid edge: write line data and tag, set valid[index], capture requested word into icache_dout → FILLED.
- FILLED: one cycle, icache_stall=0, icache_dout = requested word; equivalent to a hit cycle (accepts next request); → IDLE.
- Miss-to-data latency: 1 + request wait + response wait + 1 cycles; minimum 3 cycles after the lookup cycle.
- No requests are accepted in MISS_REQ/MISS_WAIT, whatever icache_re is.
- invalidate:
  - In IDLE/FILLED: clears all valid bits at the edge. A lookup in that same cycle uses the pre-clear valids.
  - In MISS_REQ/MISS_WAIT: latched into inv_pending. The refill still completes and its word is still delivered. All valids clear on the FILLED→IDLE edge.
- mem_resp_valid outside MISS_WAIT is ignored.
- Reset during a miss abandons it; a late response is ignored per the rule above.
- Counters wrap modulo 2^32.
- Simultaneous refill and lookup to the same index is impossible (blocking design).

Test Plan:
- Reset then fetch 0x0000_2000: miss, icache_stall=1 next cycle; mem_req_addr=0x000_0200. Respond with 128'h..._13_00000093, word0=0x00000093 → icache_dout=0x00000093 in FILLED with stall=0; miss_count=1.
- Fetch 0x2004, 0x2008, 0x200C back-to-back → three hits, one word per cycle, no stall; hit_count=3.
- Conflict: fetch 0x2000 then 0x2400 (same index, LINES=64) → second misses. Refetch 0x2000 → miss again; miss_count increments each time.
- Hold mem_req_ready=0 for 5 cycles during a miss → mem_req_valid and addr stable; stall held; exactly one handshake.
- Assert invalidate in MISS_WAIT → refilled word delivered. Following fetch of the same address misses.
- Drive reset low while in MISS_WAIT, then a late mem_resp_valid → state IDLE, outputs 0, no valid bit set, next fetch misses.
